// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if -- request/response bundle for the HI/LO multiply/divide unit.
//
// Signals
//   start  : request strobe, sampled every rising edge (master -> slave)
//   op     : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b   : operands (rs, rt)
//   flush  : abort any in-flight operation
//   busy   : operation in progress (slave -> master)
//   done   : one-cycle completion pulse, new hi/lo visible in the same cycle
//   hi, lo : HI/LO architectural registers
//
// Handshake: a request is taken on a rising edge where start=1, busy=0 and
// flush=0 with a legal op; start while busy=1 is dropped, not queued. Long
// operations answer with a single done pulse; MTHI/MTLO never raise busy/done.
// -----------------------------------------------------------------------------
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit -- iterative 32-bit multiply/divide unit with HI/LO registers.
//
// Ports
//   clk         : single clock, all state updates on posedge
//   rst         : synchronous active-high reset
//   bus         : muldiv_unit_if.slave (start/op/a/b/flush in, busy/done/hi/lo out)
//   dbg_state_o : current FSM state encoding
//
// Multiply is radix-2 shift-add, divide is radix-2 restoring; both run on
// operand magnitudes for 32 edges, then WB applies sign correction and writes
// HI/LO. busy covers exactly 33 cycles, done pulses once after WB.
//
// Configuration: define MULDIV_DIV_EN to include the divider (DIV/DIVU).
// Without it op 010/011 are treated as illegal and ignored.
// -----------------------------------------------------------------------------
module muldiv_unit (
  input  logic               clk,
  input  logic               rst,
  muldiv_unit_if.slave       bus,
  output logic [1:0]         dbg_state_o
);

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;
`endif

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] m_q, m_d;            // multiplicand / divisor magnitude
  logic [31:0] acc_hi_q, acc_hi_d;  // product high half / partial remainder
  logic [31:0] acc_lo_q, acc_lo_d;  // multiplier shifting out / quotient in
  logic        q_neg_q, q_neg_d;    // negate product or quotient at WB
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

`ifdef MULDIV_DIV_EN
  logic        is_div_q, is_div_d;
  logic        r_neg_q, r_neg_d;    // remainder takes the dividend sign
  logic        div0_q, div0_d;
  logic [32:0] trial_w;
  logic [32:0] diff_w;
  logic        ge_w;
  logic [31:0] quo_w;
  logic [31:0] rem_w;
`endif

  logic        legal_w;
  logic        neg_a_w;
  logic        neg_b_w;
  logic [31:0] mag_a_w;
  logic [31:0] mag_b_w;
  logic [32:0] sum_w;
  logic [63:0] prod_w;

  always_comb begin
`ifdef MULDIV_DIV_EN
    legal_w = (bus.op <= 3'd5);
`else
    legal_w = (bus.op == 3'd0) || (bus.op == 3'd1) ||
              (bus.op == 3'd4) || (bus.op == 3'd5);
`endif
    // op[0]=0 selects the signed flavour of both MULT and DIV
    neg_a_w = ~bus.op[0] & bus.a[31];
    neg_b_w = ~bus.op[0] & bus.b[31];
    mag_a_w = neg_a_w ? (32'd0 - bus.a) : bus.a;
    mag_b_w = neg_b_w ? (32'd0 - bus.b) : bus.b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    q_neg_d  = q_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    sum_w    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : 33'd0);
    prod_w   = q_neg_q ? (64'd0 - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    r_neg_d  = r_neg_q;
    div0_d   = div0_q;
    trial_w  = {acc_hi_q, acc_lo_q[31]};
    diff_w   = trial_w - {1'b0, m_q};
    ge_w     = (trial_w >= {1'b0, m_q});
    quo_w    = q_neg_q ? (32'd0 - acc_lo_q) : acc_lo_q;
    rem_w    = r_neg_q ? (32'd0 - acc_hi_q) : acc_hi_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush && legal_w) begin
          case (bus.op)
            3'd4: hi_d = bus.a;
            3'd5: lo_d = bus.a;
            default: begin
              acc_hi_d = 32'd0;
              acc_lo_d = mag_a_w;
              m_d      = mag_b_w;
              q_neg_d  = neg_a_w ^ neg_b_w;
              cnt_d    = 5'd0;
`ifdef MULDIV_DIV_EN
              is_div_d = bus.op[1];
              r_neg_d  = neg_a_w;
              div0_d   = (bus.b == 32'd0);
              state_d  = bus.op[1] ? S_DIV : S_MUL;
`else
              state_d  = S_MUL;
`endif
            end
          endcase
        end
      end
      S_MUL: begin
        // Add multiplicand into the high half, then shift the 64-bit pair right
        acc_hi_d = sum_w[32:1];
        acc_lo_d = {sum_w[0], acc_lo_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_WB;
      end
`ifdef MULDIV_DIV_EN
      S_DIV: begin
        // Restoring step: shift next dividend bit in, subtract when it fits.
        // A zero divisor always "fits", giving all-ones quotient, rem = |a|.
        acc_hi_d = ge_w ? diff_w[31:0] : trial_w[31:0];
        acc_lo_d = {acc_lo_q[30:0], ge_w};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_WB;
      end
`endif
      S_WB: begin
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          hi_d = rem_w;
          lo_d = div0_q ? 32'hFFFF_FFFF : quo_w;
        end else begin
          hi_d = prod_w[63:32];
          lo_d = prod_w[31:0];
        end
`else
        hi_d = prod_w[63:32];
        lo_d = prod_w[31:0];
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any progress or write-back in the same cycle
    if (state_q != S_IDLE && bus.flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      m_q      <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      q_neg_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      q_neg_q  <= q_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      r_neg_q  <= r_neg_d;
      div0_q   <= div0_d;
`endif
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit -- self-checking bench for muldiv_unit.
// Expected HI/LO come from a plain-arithmetic reference model (64-bit
// multiply, truncating divide) with the divide-by-zero rule applied on top.
// Define MULDIV_DIV_EN for both bench and RTL to exercise the divider.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_model(input logic [2:0] op_v, input logic [31:0] a_v,
                                    input logic [31:0] b_v, input logic [31:0] hi_in,
                                    input logic [31:0] lo_in, output bit long_op,
                                    output logic [31:0] hi_o, output logic [31:0] lo_o);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    hi_o    = hi_in;
    lo_o    = lo_in;
    long_op = 1'b0;
    sa      = $signed(a_v);
    sb      = $signed(b_v);
    case (op_v)
      3'd0: begin p = sa * sb; {hi_o, lo_o} = p; long_op = 1'b1; end
      3'd1: begin p = {32'd0, a_v} * {32'd0, b_v}; {hi_o, lo_o} = p; long_op = 1'b1; end
`ifdef MULDIV_DIV_EN
      3'd2: begin
        long_op = 1'b1;
        if (b_v == 32'd0) begin lo_o = 32'hFFFF_FFFF; hi_o = a_v; end
        else begin p = sa / sb; lo_o = p[31:0]; p = sa % sb; hi_o = p[31:0]; end
      end
      3'd3: begin
        long_op = 1'b1;
        if (b_v == 32'd0) begin lo_o = 32'hFFFF_FFFF; hi_o = a_v; end
        else begin lo_o = a_v / b_v; hi_o = a_v % b_v; end
      end
`endif
      3'd4: hi_o = a_v;
      3'd5: lo_o = a_v;
      default: ;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; drives one request and checks its whole outcome.
  task automatic run_op(input logic [2:0] op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input bit inject, input string tag);
    bit          long_op;
    logic [31:0] nh;
    logic [31:0] nl;
    logic [63:0] e;
    int          n;
    bit          held;
    bit          done_low;
    ref_model(op_v, a_v, b_v, m_hi, m_lo, long_op, nh, nl);
    bus.start = 1'b1; bus.op = op_v; bus.a = a_v; bus.b = b_v;
    @(negedge clk);
    bus.start = 1'b0;
    if (long_op) begin
      exp_q.push_back({nh, nl});
      n = 0; held = 1'b1; done_low = 1'b1;
      while (bus.busy && n < 100) begin
        n++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) held = 1'b0;
        if (bus.done !== 1'b0) done_low = 1'b0;
        if (inject && n == 5) begin
          bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_BEEF;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
      bus.start = 1'b0;
      e = exp_q.pop_front();
      check({tag, " busy_cycles"}, 64'(n), 64'd33);
      check({tag, " hilo_held"}, 64'(held), 64'd1);
      check({tag, " no_early_done"}, 64'(done_low), 64'd1);
      check({tag, " done"}, 64'(bus.done), 64'd1);
      check({tag, " hilo"}, {bus.hi, bus.lo}, e);
    end else begin
      check({tag, " busy"}, 64'(bus.busy), 64'd0);
      check({tag, " done"}, 64'(bus.done), 64'd0);
      check({tag, " hilo"}, {bus.hi, bus.lo}, {nh, nl});
    end
    m_hi = nh;
    m_lo = nl;
  endtask

  // Starts a long op and aborts it on busy cycle n with flush or reset.
  task automatic run_abort(input logic [2:0] op_v, input logic [31:0] a_v,
                           input logic [31:0] b_v, input int n, input bit use_rst,
                           input string tag);
    bus.start = 1'b1; bus.op = op_v; bus.a = a_v; bus.b = b_v;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < n; k++) @(negedge clk);
    check({tag, " busy_before_abort"}, 64'(bus.busy), 64'd1);
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.flush = 1'b0;
    if (use_rst) begin m_hi = 32'd0; m_lo = 32'd0; end
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " done"}, 64'(bus.done), 64'd0);
    check({tag, " hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    @(negedge clk);
    check({tag, " done_later"}, 64'(bus.done), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    rst = 1'b1; bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    bus.flush = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(negedge clk);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, "mult_neg_inject");
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg");
    run_op(3'd3, 32'h0000_0007, 32'h0000_0000, 1'b0, "divu_by_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    run_op(3'd2, 32'h0000_0064, 32'h0000_0000, 1'b0, "div_by_zero");
    run_op(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0, "illegal6");
    run_op(3'd7, 32'h3333_3333, 32'h4444_4444, 1'b0, "illegal7");

    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0, "mthi");
    run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0, "mtlo");
    run_abort(3'd0, 32'h0BAD_F00D, 32'h7654_3210, 10, 1'b0, "flush_mult");

    // start together with flush in IDLE must not be taken
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd6; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("idle_flush busy", 64'(bus.busy), 64'd0);
    check("idle_flush hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

`ifdef MULDIV_DIV_EN
    run_abort(3'd3, 32'hCAFE_0001, 32'h0000_0013, 20, 1'b1, "rst_divu");
`else
    run_abort(3'd1, 32'hCAFE_0001, 32'h0000_0013, 20, 1'b1, "rst_multu");
`endif
    run_op(3'd1, 32'd3, 32'd5, 1'b0, "multu_3x5");

    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = pick_operand();
      r_b  = pick_operand();
      run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, r_op));
    end

    @(negedge clk);
    check("final done low", 64'(bus.done), 64'd0);
    check("queue drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled every rising edge.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 illegal.
REQ-006 a  input  32  operand A: register-file read port 1 (rs).
REQ-007 b  input  32  operand B: register-file read port 2 (rt).
REQ-008 flush  input  1  abort any in-flight operation.
REQ-009 busy  output  1  operation in progress; the pipeline stalls on busy.
REQ-010 done  output  1  one-cycle pulse; new hi/lo are visible in the same cycle.
REQ-011 hi  output  32  HI register (registered output).
REQ-012 lo  output  32  LO register (registered output).

Function
REQ-013 States SHALL be IDLE, MUL, DIV and WB; only IDLE has busy=0.
REQ-014 A request SHALL be accepted at an edge E0 where start=1, busy=0, flush=0, rst=0 and op is legal.
REQ-015 start while busy=1 SHALL be ignored, with no state, hi or lo change.
REQ-016 Illegal op SHALL be ignored, with no busy and no done.
REQ-017 MTHI/MTLO SHALL load hi=a (or lo=a) at E0 and stay in IDLE; busy and done remain 0.
REQ-018 MULT/MULTU/DIV/DIVU SHALL enter MUL/DIV at E0 and latch operand magnitudes plus the sign flags at E0.
  - Operands are treated as unsigned for MULTU/DIVU.
REQ-019 Iteration SHALL be radix-2: one bit per edge, E1..E32, then WB.
  - Shift-add for multiply; restoring divide.
REQ-020 At E33 the block SHALL apply sign correction, write hi/lo, return to IDLE and set done=1 for exactly one cycle.
  - busy is 1 for exactly 33 cycles.
REQ-021 Multiply SHALL produce {hi,lo} = the full 64-bit product.
REQ-022 Divide SHALL produce lo=quotient truncated toward zero and hi=remainder, with the remainder sign equal to the dividend sign.
REQ-023 Divide by zero SHALL take normal latency and give lo=32'hFFFFFFFF, hi=a.
REQ-024 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-025 hi/lo SHALL hold their prior values throughout busy; only WB or MTHI/MTLO modify them.
REQ-026 flush=1 with busy=1 SHALL return the block to IDLE at the next edge, with hi/lo unchanged and no done.
REQ-027 flush=1 with start=1 in IDLE SHALL suppress acceptance.
REQ-028 The cycle after done, a new start SHALL be accepted normally (back-to-back operation).

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, overriding start and flush.
REQ-030 Reset mid-operation SHALL discard the operation, with no done pulse.

Configuration
REQ-031 Macro MULDIV_DIV_EN defined SHALL include the divider and the DIV/DIVU behaviour of REQ-022..REQ-024.
REQ-032 Macro MULDIV_DIV_EN undefined SHALL remove the divider and DIV state, and SHALL treat op 010/011 as illegal per REQ-016.

Verification
REQ-033 MULTU a=FFFFFFFF b=FFFFFFFF -> busy for 33 cycles, then done with hi=FFFFFFFE, lo=00000001.
REQ-034 MULT a=FFFFFFFE b=00000003 -> hi=FFFFFFFF, lo=FFFFFFFA; an intervening start while busy is ignored.
REQ-035 DIV a=FFFFFFF9 b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=7 b=0 -> lo=FFFFFFFF, hi=00000007.
  - Without MULDIV_DIV_EN: no busy and hi/lo unchanged.
REQ-036 After MTHI a=12345678 and MTLO a=9ABCDEF0, start MULT and assert flush on the 10th busy cycle.
  - Required: busy=0 next cycle, no done, hi=12345678, lo=9ABCDEF0.
REQ-037 rst asserted on the 20th busy cycle of DIVU -> next cycle hi=lo=0, busy=0, no done.
  - A following MULTU 3*5 then completes normally with lo=0000000F.
